// File: rtl/basic_system_ocram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port on-chip RAM.
// Reads return a fixed one cycle after grant; writes complete in the grant cycle.
module basic_system_ocram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int BE_W   = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    logic act0, act1;
    logic grant_vld, winner, win_read, win_write;
    logic last_grant_q, last_grant_d;
    logic rd_pending_q, rd_pending_d;
    logic rd_owner_q, rd_owner_d;

    always_comb begin
        act0      = m0_read | m0_write;
        act1      = m1_read | m1_write;
        grant_vld = !reset && (act0 || act1);

        // Under contention the requester that did not win last time goes next.
        if (act0 && act1) begin
            winner = ~last_grant_q;
        end else if (act1) begin
            winner = M1;
        end else begin
            winner = M0;
        end

        // A request with both read and write high is handled as a write.
        win_write = (winner == M1) ? m1_write : m0_write;
        win_read  = ((winner == M1) ? m1_read : m0_read) && !win_write;

        last_grant_d = grant_vld ? winner : last_grant_q;
        rd_pending_d = grant_vld && win_read;
        rd_owner_d   = winner;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= M1;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= M0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign m0_waitrequest = !(grant_vld && (winner == M0));
    assign m1_waitrequest = !(grant_vld && (winner == M1));

    assign ram_address    = (winner == M1) ? m1_address    : m0_address;
    assign ram_byteenable = (winner == M1) ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = (winner == M1) ? m1_writedata  : m0_writedata;
    assign ram_chipselect = grant_vld;
    assign ram_write      = grant_vld && win_write;
    assign ram_clken      = 1'b1;

    // Read data is broadcast; only the valid strobe is steered to the owner.
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = !reset && rd_pending_q && (rd_owner_q == M0);
    assign m1_readdatavalid = !reset && rd_pending_q && (rd_owner_q == M1);

endmodule
